// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: divider FSM states and the fixed divide timing
// that the HI/LO interlock relies on when stalling mfhi/mflo.
package mips_alu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam int DIV_STEPS   = 32;
  localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, record the quotient bit. No state, no backpressure.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic [W-1:0] dvd_nxt
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       fits;

  always_comb begin
    shifted = {rem[W-1:0], dvd[W-1]};
    diff    = shifted - {1'b0, dvs};
    // A set top bit means the true shifted value exceeds W+1 bits, so it always fits.
    fits    = rem[W] | (shifted >= {1'b0, dvs});
    if (fits) begin
      rem_nxt = diff;
      dvd_nxt = {dvd[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted;
      dvd_nxt = {dvd[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential div/divu for HI/LO: quotient to q, remainder to r, done 34 cycles after start.
// No backpressure: start at any time aborts an in-flight divide and restarts it.
module divider
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

  div_state_e       state;
  logic [CW-1:0]    i;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             dvs_zero;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  div_step #(.W(WIDTH)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  assign busy = (state != DIV_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DIV_IDLE;
      i           <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvs_zero    <= 1'b0;
      q           <= '0;
      r           <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        neg_q       <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r       <= is_signed & a[WIDTH-1];
        dvd         <= mag(a, is_signed);
        dvs         <= mag(b, is_signed);
        dvs_zero    <= (b == '0);
        rem         <= '0;
        i           <= '0;
        div_by_zero <= 1'b0;
        state       <= DIV_RUN;
      end else begin
        case (state)
          DIV_RUN: begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            i   <= i + CW'(1);
            if (i == LAST) state <= DIV_FIX;
          end
          DIV_FIX: begin
            // Divide by zero leaves the all-ones quotient uncorrected; the
            // remainder correction already reproduces the dividend.
            q           <= dvs_zero ? '1 : (neg_q ? -dvd : dvd);
            r           <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            div_by_zero <= dvs_zero;
            done        <= 1'b1;
            state       <= DIV_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider: every-cycle compare against an
// arithmetic reference model, plus literal directed cases.
module tb_divider;
  import mips_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural corner cases.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    int          sx;
    int          sy;
    logic [31:0] qq;
    logic [31:0] rr;
    if (y == 32'd0) begin
      qq = 32'hFFFFFFFF;
      rr = x;
    end else if (!s) begin
      qq = x / y;
      rr = x % y;
    end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      qq = 32'h80000000;
      rr = 32'd0;
    end else begin
      sx = x;
      sy = y;
      qq = sx / sy;
      rr = sx % sy;
    end
    return {rr, qq};
  endfunction

  // Model state: one pending divide (a restart replaces it) and the held outputs.
  bit          pend_vld   = 1'b0;
  int          pend_start = 0;
  int          pend_due   = 0;
  logic [31:0] pend_q     = '0;
  logic [31:0] pend_r     = '0;
  logic        pend_dz    = 1'b0;
  logic [31:0] exp_q      = '0;
  logic [31:0] exp_r      = '0;
  logic        exp_dz     = 1'b0;

  always @(negedge clk) begin
    bit due;
    due = pend_vld && (cyc == pend_due);
    if (due) begin
      exp_q  = pend_q;
      exp_r  = pend_r;
      exp_dz = pend_dz;
    end
    chk("mon_done", {31'd0, done}, {31'd0, due});
    chk("mon_busy", {31'd0, busy},
        {31'd0, pend_vld && (cyc > pend_start) && (cyc < pend_due)});
    chk("mon_q", q, exp_q);
    chk("mon_r", r, exp_r);
    chk("mon_dz", {31'd0, div_by_zero}, {31'd0, exp_dz});
    if (due) pend_vld = 1'b0;
    if (reset) begin
      pend_vld = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_dz   = 1'b0;
    end else if (start) begin
      pend_vld       = 1'b1;
      pend_start     = cyc;
      pend_due       = cyc + DIV_LATENCY;
      {pend_r, pend_q} = ref_div(a, b, is_signed);
      pend_dz        = (b == 32'd0);
      exp_dz         = 1'b0;
    end
  end

  // Called just after a start edge; watches until done or the cycle budget expires.
  task automatic wait_done(output int lat, output int nb, output bit seen);
    lat  = 1;
    nb   = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) nb++;
        lat++;
      end
    end
  endtask

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input string nm);
    int lat;
    int nb;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tbv; is_signed = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    wait_done(lat, nb, seen);
    chk({nm, "_latency"}, lat, DIV_LATENCY);
    chk({nm, "_busy_cycles"}, nb, 33);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  // Drives start right now (caller sits mid-cycle) and drops it after the edge.
  task automatic start_now(input logic [31:0] ta, input logic [31:0] tbv, input logic ts);
    a = ta; b = tbv; is_signed = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int nb;
    int ndone;
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_q", q, 32'd0);
    chk("reset_r", r, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);

    run_div(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, "u100_7");
    run_div(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, "s_m7_2");
    run_div(32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, "u_m7_2");
    run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, "s_ovf");
    run_div(32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1'b1, "s_dz");
    run_div(32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1, "u_dz");
    run_div(32'h87654321,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h87654321,   1'b1, "s_neg_dz");
    run_div(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, "dz_clear");
    run_div(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, "s_7_m2");

    // Restart ten cycles into a divide: only the second one may complete.
    @(posedge clk); #1;
    start_now(32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    start_now(32'd50, 32'd3, 1'b0);
    wait_done(lat, nb, seen);
    chk("abort_latency", lat, DIV_LATENCY);
    chk("abort_q", q, 32'd16);
    chk("abort_r", r, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_extra_done", ndone, 0);

    // Reset at cycle 15 of a divide, with a competing start in the same cycle.
    @(posedge clk); #1;
    start_now(32'd1000, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1; a = 32'd5; b = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_q", q, 32'd0);
    chk("midreset_r", r, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, "after_reset");

    // Random back-to-back traffic; new starts land in the done cycle.
    @(negedge clk);
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int          sel;
      ra  = $urandom;
      rb  = $urandom;
      rs  = $urandom_range(0, 1);
      sel = $urandom_range(0, 99);
      if (sel < 5) rb = 32'd0;
      else if (sel < 10) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
        rs = 1'b1;
      end else if (sel < 40) rb = 32'($urandom_range(1, 255));
      start_now(ra, rb, rs);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(1, 32)) @(negedge clk);
        start_now($urandom, 32'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)));
      end
      wait_done(lat, nb, seen);
      chk("rand_latency", lat, DIV_LATENCY);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
